// File: rtl/sprite_pkg.sv
// Shared types, sizes and the sprite ROM address mapping for the sprite blitter.
package sprite_pkg;
  localparam int unsigned SPR_W  = 51;
  localparam int unsigned SPR_H  = 43;
  localparam int unsigned FB_W   = 320;
  localparam int unsigned FB_H   = 240;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned ROM_AW = 12;
  localparam int unsigned FB_AW  = 17;
  localparam int unsigned POS_W  = 10;
  localparam int unsigned PIX_W  = 11;
  localparam int unsigned SX_W   = $clog2(SPR_W);
  localparam int unsigned SY_W   = $clog2(SPR_H);

  localparam logic [IDX_W-1:0] TRANSP_IDX = '0;

  typedef enum logic [2:0] {IDLE, READ, DATA, WRITE, ADV, DONE} blit_state_t;

  // Source texel for sprite column sx of row sy, mirrored when flip is set.
  function automatic logic [ROM_AW-1:0] rom_addr_f(input logic [SX_W-1:0] sx,
                                                   input logic [SY_W-1:0] sy,
                                                   input logic            flip);
    int unsigned col;
    col = flip ? (SPR_W - 1 - 32'(sx)) : 32'(sx);
    return ROM_AW'(32'(sy) * SPR_W + col);
  endfunction
endpackage

// File: rtl/sprite_blitter_if.sv
// Sprite ROM read port and frame-buffer write port of the blitter.
interface sprite_blitter_if;
  import sprite_pkg::*;

  logic [ROM_AW-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [IDX_W-1:0]  fb_data;
  logic              fb_ready;

  modport master (output rom_address, fb_we, fb_addr, fb_data,
                  input  rom_q, fb_ready);
  modport slave  (input  rom_address, fb_we, fb_addr, fb_data,
                  output rom_q, fb_ready);
endinterface

// File: rtl/sprite_blitter_addr_gen.sv
// Sprite walk counters, flip mapping, registered ROM address and destination clip/address.
module blit_addr_gen
  import sprite_pkg::*;
(
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [POS_W-1:0]  pos_x,
  input  logic [POS_W-1:0]  pos_y,
  input  logic              flip_x,
  output logic [ROM_AW-1:0] rom_address,
  output logic [FB_AW-1:0]  fb_addr_c,
  output logic              in_bounds_c,
  output logic              last_c
);
  logic [SX_W-1:0]  sx_q, sx_d;
  logic [SY_W-1:0]  sy_q, sy_d;
  logic [POS_W-1:0] pos_x_q, pos_y_q;
  logic             flip_q;
  logic [PIX_W-1:0] px, py;
  logic             row_end;

  always_comb begin
    row_end     = (sx_q == SX_W'(SPR_W - 1));
    last_c      = row_end && (sy_q == SY_W'(SPR_H - 1));
    sx_d        = row_end ? '0 : sx_q + SX_W'(1);
    sy_d        = row_end ? sy_q + SY_W'(1) : sy_q;
    px          = PIX_W'(pos_x_q) + PIX_W'(sx_q);
    py          = PIX_W'(pos_y_q) + PIX_W'(sy_q);
    in_bounds_c = (px < PIX_W'(FB_W)) && (py < PIX_W'(FB_H));
    fb_addr_c   = FB_AW'(32'(py) * FB_W + 32'(px));
  end

  // ROM address is loaded from the upcoming (sx,sy) so it is stable for the whole READ cycle.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      sx_q        <= '0;
      sy_q        <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      flip_q      <= 1'b0;
      rom_address <= '0;
    end else if (clear) begin
      sx_q        <= '0;
      sy_q        <= '0;
      pos_x_q     <= pos_x;
      pos_y_q     <= pos_y;
      flip_q      <= flip_x;
      rom_address <= rom_addr_f('0, '0, flip_x);
    end else if (advance) begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      rom_address <= rom_addr_f(sx_d, sy_d, flip_q);
    end
  end
endmodule

// File: rtl/sprite_blitter.sv
// Copies one palette-indexed sprite from the sprite ROM into the frame buffer
// with transparency, horizontal flip and edge clipping.
module sprite_blitter
  import sprite_pkg::*;
(
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  input  logic             flip_x,
  output logic             busy,
  output logic             done,
  sprite_blitter_if.master bus
);
  blit_state_t       state_q, state_d;
  logic              busy_d, done_d;
  logic              fb_we_q, fb_we_d;
  logic [FB_AW-1:0]  fb_addr_q, fb_addr_d, fb_addr_c;
  logic [IDX_W-1:0]  fb_data_q, fb_data_d;
  logic              clear_c, advance_c, in_bounds_c, last_c;
  logic [ROM_AW-1:0] rom_address;

  blit_addr_gen u_addr_gen (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .clear       (clear_c),
    .advance     (advance_c),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flip_x      (flip_x),
    .rom_address (rom_address),
    .fb_addr_c   (fb_addr_c),
    .in_bounds_c (in_bounds_c),
    .last_c      (last_c)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy;
    done_d    = 1'b0;
    fb_we_d   = fb_we_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    clear_c   = 1'b0;
    advance_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clear_c = 1'b1;
          busy_d  = 1'b1;
          state_d = READ;
        end
      end
      READ: state_d = DATA;
      DATA: begin
        if ((bus.rom_q != TRANSP_IDX) && in_bounds_c) begin
          fb_we_d   = 1'b1;
          fb_addr_d = fb_addr_c;
          fb_data_d = bus.rom_q;
          state_d   = WRITE;
        end else begin
          state_d = ADV;
        end
      end
      // Write stays presented until the frame buffer takes it.
      WRITE: begin
        if (bus.fb_ready) begin
          fb_we_d = 1'b0;
          state_d = ADV;
        end
      end
      ADV: begin
        if (last_c) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          advance_c = 1'b1;
          state_d   = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      done      <= done_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign bus.rom_address = rom_address;
  assign bus.fb_we       = fb_we_q;
  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_data     = fb_data_q;
endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Writer side of the sprite path. Copies one palette-indexed sprite from a synchronous sprite ROM into the indexed frame buffer at a requested (x,y) position.
- The frame buffer is later read out by the per-sprite display/palette logic.
- Handles transparency, horizontal flip, and clipping at the frame-buffer edges.
- Sits between the game-logic FSM (start/done handshake) and the frame-buffer write port (we/ready handshake).

Parameters:
- SPR_W, 51, sprite width in pixels
- SPR_H, 43, sprite height in pixels
- FB_W, 320, frame-buffer width in pixels
- FB_H, 240, frame-buffer height in pixels
- IDX_W, 4, palette index width
- ROM_AW, 12, sprite ROM address width (must satisfy 2^ROM_AW >= SPR_W*SPR_H)
- FB_AW, 17, frame-buffer address width (must satisfy 2^FB_AW >= FB_W*FB_H)
- TRANSP_IDX, 0, palette index treated as transparent (not written)

Ports:
- vga_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- pos_x  in  10  destination left column; latched on accepted start
- pos_y  in  10  destination top row; latched on accepted start
- flip_x  in  1  mirror horizontally; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the copy completes
- rom_address  out  ROM_AW  sprite ROM address
- rom_q  in  IDX_W  ROM data, valid exactly 1 cycle after rom_address
- fb_we  out  1  frame-buffer write request
- fb_addr  out  FB_AW  frame-buffer write address
- fb_data  out  IDX_W  palette index to write
- fb_ready  in  1  write accepted when fb_we && fb_ready on the same edge

Behaviour:
- Clock/reset: one clock, vga_clk. Reset is synchronous and active-high. One clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, rom_address=0. Counters sx, sy=0. State=IDLE.
- State IDLE:
  - start=1 latches pos_x, pos_y, flip_x; clears sx, sy; next state READ.
  - start in any other state is ignored (no queueing).
- State READ: rom_address = sy*SPR_W + (flip_x ? SPR_W-1-sx : sx). Next state DATA.
- State DATA: rom_q is valid. Compute px=pos_x+sx and py=pos_y+sy, each 11 bits so there is no wrap.
  - Write the pixel if rom_q != TRANSP_IDX and px < FB_W and py < FB_H: register fb_addr = py*FB_W+px and fb_data = rom_q, set fb_we=1, next state WRITE.
  - Otherwise skip: next state ADV with fb_we=0.
- State WRITE: hold fb_we, fb_addr and fb_data stable until fb_ready=1. On that edge drop fb_we (it is low the next cycle); next state ADV.
- State ADV:
  - sx == SPR_W-1 and sy == SPR_H-1: next state DONE.
  - Else if sx == SPR_W-1: sx=0, sy+1.
  - Else sx+1.
  - Next state READ.
- State DONE: done=1 for exactly one cycle, busy=0 in the same cycle; next state IDLE.
- busy=1 in READ, DATA, WRITE and ADV.
- Write accounting:
  - No pixel is ever written twice.
  - Writes go out in raster order over destination rows.
  - Fully clipped or fully transparent sprite: zero writes, done still pulses.
- Latency per pixel:
  - Opaque, in bounds, fb_ready tied 1: 4 cycles.
  - Skipped: 3 cycles.
- Reset mid-operation: the state returns to IDLE on the next edge and fb_we is low that cycle. The partial copy is abandoned and done does not pulse.
- start together with reset: reset wins.
- Arithmetic: all products are unsigned, computed at full width, then truncated to ROM_AW / FB_AW. Parameter checks guarantee no loss from the truncation.

Decomposition:
- Shared package sprite_pkg holds:
  - FB_W, FB_H, IDX_W, FB_AW, TRANSP_IDX
  - state typedef blit_state_t {IDLE, READ, DATA, WRITE, ADV, DONE}
- One natural sub-module: blit_addr_gen. Owns the sx/sy counters, flip mapping, ROM address, px/py and the clip flag.
- The FSM and write handshake stay in the top module.

Test Plan:
- Reset: assert reset for 2 cycles -> busy=0, done=0, fb_we=0, all outputs 0.
- Basic copy, fb_ready=1:
  - Stimulus: ROM all index 5, start pos=(10,20), flip_x=0.
  - Expect 2193 writes. First write fb_addr=20*320+10=6410, data=5. Last write fb_addr=62*320+60=19900.
  - done pulses once, 4*2193+1 cycles after start.
- Transparency + flip:
  - Stimulus: ROM row 0 = index 0 except col 0 = 7, all other rows 0; flip_x=1, pos=(0,0).
  - Expect exactly one write: fb_addr=50, data=7.
- Clipping:
  - Stimulus: pos=(300,230), all-opaque ROM.
  - Expect writes only for px 300..319 and py 230..239: 200 writes, none with fb_addr >= 76800. done pulses.
- Backpressure:
  - Stimulus: fb_ready low for 3 cycles on each write.
  - Expect fb_we, fb_addr and fb_data stable while waiting. Write count unchanged versus the basic copy. start pulsed while busy is ignored (still exactly one done).
- Reset mid-copy:
  - Stimulus: assert reset after 100 writes.
  - Expect fb_we=0 next cycle, no done pulse. A subsequent start runs a full copy correctly.
